// File: rtl/arbiter.sv
`default_nettype none
// ============================================================================
// Module   : arbiter
// Brief    : Two-master AHB-style bus arbiter. Fixed priority (master 1 wins
//            ties) with lock and burst hold, SPLIT masking and RETRY
//            re-arbitration. Publishes the bus owner ID and lock status.
//            Optional build macro ARBITER_ROUND_ROBIN_EN: ties go to the
//            master that did not own the bus last.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req1,
  input  logic        lockm1,
  input  logic        req2,
  input  logic        lockm2,
  input  logic [31:0] sb_addr_ar,
  input  logic [1:0]  sb_split_ar,
  input  logic [1:0]  sb_trans_ar,
  input  logic [2:0]  sb_burst_ar,
  input  logic [1:0]  sb_resp_ar,
  input  logic        sb_ready_ar,
  output logic        gnt1,
  output logic        gnt2,
  output logic [1:0]  hmasters,
  output logic        hmasterLock
);

  localparam logic [1:0] c_TRANS_BUSY = 2'b01;
  localparam logic [1:0] c_TRANS_SEQ  = 2'b11;
  localparam logic [1:0] c_RESP_RETRY = 2'b10;
  localparam logic [1:0] c_RESP_SPLIT = 2'b11;
  localparam logic [1:0] c_OWNER_M1   = 2'b01;
  localparam logic [1:0] c_OWNER_M2   = 2'b10;

  logic       r_gnt1;
  logic       r_gnt2;
  logic [1:0] r_hmasters;
  logic       r_hmaster_lock;
  logic [1:0] r_split_mask;

  logic       w_hold;
  logic       w_split;
  logic       w_retry;
  logic       w_arb;
  logic [1:0] w_split_set;
  logic [1:0] w_mask_eff;
  logic       w_elig1;
  logic       w_elig2;
  logic       w_pick1;
  logic       w_pick2;
  logic       w_unused_inputs;

  // Address and burst type are carried for interface compatibility only.
  assign w_unused_inputs = ^{sb_addr_ar, sb_burst_ar};

  // Lock of the granted master or an in-flight burst freezes the grant.
  assign w_hold = (r_gnt1 & lockm1) | (r_gnt2 & lockm2) |
                  (sb_trans_ar == c_TRANS_SEQ) | (sb_trans_ar == c_TRANS_BUSY);

  assign w_split = sb_ready_ar & (sb_resp_ar == c_RESP_SPLIT);
  assign w_retry = sb_ready_ar & (sb_resp_ar == c_RESP_RETRY);

  // SPLIT and RETRY override lock/burst hold and re-arbitrate immediately.
  assign w_arb = (sb_ready_ar & ~w_hold) | w_split | w_retry;

  // A SPLIT masks whoever currently owns the address phase.
  assign w_split_set = w_split ? {r_hmasters == c_OWNER_M2, r_hmasters == c_OWNER_M1}
                               : 2'b00;

  // The master being split this cycle is already excluded from this arbitration.
  assign w_mask_eff = r_split_mask | w_split_set;
  assign w_elig1    = req1 & ~w_mask_eff[0];
  assign w_elig2    = req2 & ~w_mask_eff[1];

`ifdef ARBITER_ROUND_ROBIN_EN
  logic r_last_m2;

  // Remember which master received the most recent grant (reset: master 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_m2 <= 1'b1;
    end else if (w_arb && (w_pick1 || w_pick2)) begin
      r_last_m2 <= w_pick2;
    end
  end
`endif

  // Select the winner among eligible requesters.
  always_comb begin
    w_pick1 = 1'b0;
    w_pick2 = 1'b0;
    if (w_elig1 && w_elig2) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      w_pick1 = r_last_m2;
      w_pick2 = ~r_last_m2;
`else
      w_pick1 = 1'b1;
`endif
    end else begin
      w_pick1 = w_elig1;
      w_pick2 = w_elig2;
    end
  end

  // Grant registers: updated only at arbitration points, otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt1 <= 1'b0;
      r_gnt2 <= 1'b0;
    end else if (w_arb) begin
      r_gnt1 <= w_pick1;
      r_gnt2 <= w_pick2;
    end
  end

  // Owner ID and lock follow the grant one ready edge later (address handover).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hmasters     <= 2'b00;
      r_hmaster_lock <= 1'b0;
    end else if (sb_ready_ar) begin
      r_hmasters     <= {r_gnt2, r_gnt1};
      r_hmaster_lock <= (r_gnt1 & lockm1) | (r_gnt2 & lockm2);
    end
  end

  // Split mask: release clears, a same-cycle SPLIT on the same bit wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_split_mask <= 2'b00;
    end else begin
      r_split_mask <= (r_split_mask & ~sb_split_ar) | w_split_set;
    end
  end

  assign gnt1        = r_gnt1;
  assign gnt2        = r_gnt2;
  assign hmasters    = r_hmasters;
  assign hmasterLock = r_hmaster_lock;

endmodule
`default_nettype wire

// File: tb/tb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter
// Brief    : Self-checking bench for arbiter (default fixed-priority build).
//            Table of per-cycle stimulus with hand-computed expected outputs,
//            plus hand-written asynchronous reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter;

  typedef struct {
    logic       req1;
    logic       lockm1;
    logic       req2;
    logic       lockm2;
    logic [1:0] split;
    logic [1:0] trans;
    logic [1:0] resp;
    logic       ready;
    logic       e_gnt1;
    logic       e_gnt2;
    logic [1:0] e_hm;
    logic       e_lock;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req1;
  logic        lockm1;
  logic        req2;
  logic        lockm2;
  logic [31:0] sb_addr_ar;
  logic [1:0]  sb_split_ar;
  logic [1:0]  sb_trans_ar;
  logic [2:0]  sb_burst_ar;
  logic [1:0]  sb_resp_ar;
  logic        sb_ready_ar;
  logic        gnt1;
  logic        gnt2;
  logic [1:0]  hmasters;
  logic        hmasterLock;

  int n_checks;
  int n_pass;

  vec_t vecs[$];

  arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req1        (req1),
    .lockm1      (lockm1),
    .req2        (req2),
    .lockm2      (lockm2),
    .sb_addr_ar  (sb_addr_ar),
    .sb_split_ar (sb_split_ar),
    .sb_trans_ar (sb_trans_ar),
    .sb_burst_ar (sb_burst_ar),
    .sb_resp_ar  (sb_resp_ar),
    .sb_ready_ar (sb_ready_ar),
    .gnt1        (gnt1),
    .gnt2        (gnt2),
    .hmasters    (hmasters),
    .hmasterLock (hmasterLock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r1, input logic l1, input logic r2, input logic l2,
                              input logic [1:0] sp, input logic [1:0] tr, input logic [1:0] rs,
                              input logic rdy, input logic g1, input logic g2,
                              input logic [1:0] hm, input logic hl);
    vec_t v;
    v.req1 = r1; v.lockm1 = l1; v.req2 = r2; v.lockm2 = l2;
    v.split = sp; v.trans = tr; v.resp = rs; v.ready = rdy;
    v.e_gnt1 = g1; v.e_gnt2 = g2; v.e_hm = hm; v.e_lock = hl;
    return v;
  endfunction

  task automatic check(input string name, input logic g1, input logic g2,
                       input logic [1:0] hm, input logic hl);
    n_checks++;
    if (gnt1 === g1 && gnt2 === g2 && hmasters === hm && hmasterLock === hl) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gnt1=%b gnt2=%b hmasters=%b lock=%b, want gnt1=%b gnt2=%b hmasters=%b lock=%b",
               name, gnt1, gnt2, hmasters, hmasterLock, g1, g2, hm, hl);
    end
  endtask

  task automatic drive(input vec_t v);
    req1        = v.req1;
    lockm1      = v.lockm1;
    req2        = v.req2;
    lockm2      = v.lockm2;
    sb_split_ar = v.split;
    sb_trans_ar = v.trans;
    sb_resp_ar  = v.resp;
    sb_ready_ar = v.ready;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //            r1 l1 r2 l2 split  trans  resp   rdy g1 g2 hm     hl
    // basic grant and owner handover
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b00, 0)); // 0
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 0)); // 1
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b01, 0)); // 2
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b10, 0)); // 3
    // ready low holds everything
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1, 2'b10, 0)); // 4
    // SEQ and BUSY hold the grant
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b11, 2'b00, 1, 0, 1, 2'b10, 0)); // 5
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b01, 2'b00, 1, 0, 1, 2'b10, 0)); // 6
    // NONSEQ is an arbitration point, master 1 wins the tie
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b10, 2'b00, 1, 1, 0, 2'b10, 0)); // 7
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 0)); // 8
    // SPLIT of master 1: masked, master 2 granted
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b10, 2'b11, 1, 0, 1, 2'b01, 0)); // 9
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b10, 0)); // 10
    // release master 1; it regains the bus at the next arbitration point
    vecs.push_back(mk(1, 0, 1, 0, 2'b01, 2'b00, 2'b00, 1, 0, 1, 2'b10, 0)); // 11
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b10, 0)); // 12
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 0)); // 13
    // master 2 locked ownership blocks master 1 until the lock drops
    vecs.push_back(mk(0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b01, 0)); // 14
    vecs.push_back(mk(1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b10, 1)); // 15
    vecs.push_back(mk(1, 0, 1, 1, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b10, 1)); // 16
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b10, 0)); // 17
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 0)); // 18
    // RETRY breaks a lock hold
    vecs.push_back(mk(1, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 1)); // 19
    vecs.push_back(mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b10, 1, 0, 1, 2'b01, 1)); // 20
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b10, 0)); // 21
    // ERROR behaves like OKAY
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 2'b00, 2'b01, 1, 1, 0, 2'b10, 0)); // 22
    // no request: grants drop, owner goes idle one ready edge later
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b01, 0)); // 23
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0)); // 24
    // SPLIT and release on the same bit: set wins
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b00, 0)); // 25
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b10, 0)); // 26
    vecs.push_back(mk(0, 0, 1, 0, 2'b10, 2'b00, 2'b11, 1, 0, 0, 2'b10, 0)); // 27
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0)); // 28
    vecs.push_back(mk(0, 0, 1, 0, 2'b10, 2'b00, 2'b00, 1, 0, 0, 2'b00, 0)); // 29
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 1, 2'b00, 0)); // 30
    // master 2 owns the bus mid-burst
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 2'b11, 2'b00, 1, 0, 1, 2'b10, 0)); // 31

    rst         = 1'b1;
    req1        = 1'b0;
    lockm1      = 1'b0;
    req2        = 1'b0;
    lockm2      = 1'b0;
    sb_addr_ar  = 32'hDEAD_BEEF;
    sb_split_ar = 2'b00;
    sb_trans_ar = 2'b00;
    sb_burst_ar = 3'b001;
    sb_resp_ar  = 2'b00;
    sb_ready_ar = 1'b0;

    #2;
    check("reset_state", 1'b0, 1'b0, 2'b00, 1'b0);
    #5;
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].e_gnt1, vecs[i].e_gnt2, vecs[i].e_hm, vecs[i].e_lock);
    end

    // Asynchronous reset while master 2 owns the bus in a SEQ burst.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", 1'b0, 1'b0, 2'b00, 1'b0);

    // Arbitration restarts from idle after release.
    @(negedge clk);
    rst         = 1'b0;
    req1        = 1'b0;
    req2        = 1'b1;
    sb_trans_ar = 2'b00;
    sb_resp_ar  = 2'b00;
    sb_split_ar = 2'b00;
    sb_ready_ar = 1'b1;
    @(posedge clk);
    #1;
    check("restart_grant", 1'b0, 1'b1, 2'b00, 1'b0);
    @(posedge clk);
    #1;
    check("restart_owner", 1'b0, 1'b1, 2'b10, 1'b0);

    // Reset clears the split mask: split master 1, reset, master 1 wins again.
    req1 = 1'b1;
    @(posedge clk);
    #1;
    check("pre_split_grant", 1'b1, 1'b0, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    check("pre_split_owner", 1'b1, 1'b0, 2'b01, 1'b0);
    sb_resp_ar = 2'b11;
    @(posedge clk);
    #1;
    check("split_m1", 1'b0, 1'b1, 2'b01, 1'b0);
    sb_resp_ar = 2'b00;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mask_cleared_by_reset", 1'b1, 1'b0, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
